// File: rtl/bin_ratio_input_loader_pkg.sv
// Shared types and widths for the first-layer input loader and its helpers.
package bin_ratio_input_loader_pkg;

    localparam int INPUT_ADDR_W = 10;
    localparam int ACT_W        = 8;

    typedef enum logic [1:0] {
        LOAD,
        ZERO_FILL,
        DONE,
        WAIT_LAYER
    } loader_state_t;

endpackage

// File: rtl/bin_ratio_input_loader_bin_compress.sv
// Saturating right-shift compression of a raw count down to an activation byte.
module bin_compress
    import bin_ratio_input_loader_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SHIFT = 2
) (
    input  logic [CNT_W-1:0] count,
    output logic [ACT_W-1:0] value
);

    // Zero-extended so the slice below is valid even for counts narrower than a byte.
    logic [CNT_W+ACT_W-1:0] shifted;

    assign shifted = {{ACT_W{1'b0}}, count} >> SHIFT;
    assign value   = (|shifted[CNT_W+ACT_W-1:ACT_W]) ? {ACT_W{1'b1}} : shifted[ACT_W-1:0];

endmodule

// File: rtl/bin_ratio_input_loader.sv
// Streams compressed spectrum bins into the first layer's input memory, zero-fills
// short frames, and holds off new input until the layer releases the memory.
module bin_ratio_input_loader
    import bin_ratio_input_loader_pkg::*;
#(
    parameter int N_BINS = 1023,
    parameter int CNT_W  = 16,
    parameter int SHIFT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    raw_valid,
    output logic                    raw_ready,
    input  logic [CNT_W-1:0]        raw_count,
    input  logic                    raw_last,
    input  logic                    DATA_out_ready,
    output logic [INPUT_ADDR_W-1:0] LOAD_input_value_ADDR,
    output logic                    LOAD_input_en,
    output logic [ACT_W-1:0]        Pre_processed_dat,
    output logic                    PP_DONE,
    output logic                    short_frame
);

    localparam logic [INPUT_ADDR_W-1:0] LAST_IDX = INPUT_ADDR_W'(N_BINS - 1);

    loader_state_t             state, state_next;
    logic [INPUT_ADDR_W-1:0]   idx, idx_next;
    logic [INPUT_ADDR_W-1:0]   addr_next;
    logic [ACT_W-1:0]          dat_next;
    logic [ACT_W-1:0]          compressed;
    logic                      en_next;
    logic                      pp_next;
    logic                      short_next;

    bin_compress #(
        .CNT_W (CNT_W),
        .SHIFT (SHIFT)
    ) u_compress (
        .count (raw_count),
        .value (compressed)
    );

    // Ready depends only on state; gated by reset so every output reads 0 while held.
    assign raw_ready = rst_n & (state == LOAD);

    always_comb begin
        state_next = state;
        idx_next   = idx;
        en_next    = 1'b0;
        addr_next  = LOAD_input_value_ADDR;
        dat_next   = Pre_processed_dat;
        pp_next    = 1'b0;
        short_next = short_frame;

        case (state)
            LOAD: begin
                if (raw_valid) begin
                    en_next   = 1'b1;
                    addr_next = idx;
                    dat_next  = compressed;
                    idx_next  = idx + 1'b1;
                    if (idx == '0) begin
                        short_next = 1'b0;
                    end
                    if (idx == LAST_IDX) begin
                        state_next = DONE;
                    end else if (raw_last) begin
                        state_next = ZERO_FILL;
                        short_next = 1'b1;
                    end
                end
            end
            ZERO_FILL: begin
                en_next   = 1'b1;
                addr_next = idx;
                dat_next  = '0;
                idx_next  = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                pp_next    = 1'b1;
                state_next = WAIT_LAYER;
            end
            WAIT_LAYER: begin
                if (DATA_out_ready) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = LOAD;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= LOAD;
            idx                   <= '0;
            LOAD_input_en         <= 1'b0;
            LOAD_input_value_ADDR <= '0;
            Pre_processed_dat     <= '0;
            PP_DONE               <= 1'b0;
            short_frame           <= 1'b0;
        end else begin
            state                 <= state_next;
            idx                   <= idx_next;
            LOAD_input_en         <= en_next;
            LOAD_input_value_ADDR <= addr_next;
            Pre_processed_dat     <= dat_next;
            PP_DONE               <= pp_next;
            short_frame           <= short_next;
        end
    end

endmodule

// File: tb/tb_bin_ratio_input_loader.sv
// Directed bench: whole frames checked cycle by cycle against hand-derived tables.
module tb_bin_ratio_input_loader;

    localparam int N_BINS = 1023;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        raw_valid;
    logic        raw_ready;
    logic [15:0] raw_count;
    logic        raw_last;
    logic        DATA_out_ready;
    logic [9:0]  LOAD_input_value_ADDR;
    logic        LOAD_input_en;
    logic [7:0]  Pre_processed_dat;
    logic        PP_DONE;
    logic        short_frame;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] count;
        logic [7:0]  expected;
    } sat_vec_t;

    sat_vec_t    sat_tab [6];
    logic [15:0] cnt_tab [N_BINS];
    logic [7:0]  exp_tab [N_BINS];

    bin_ratio_input_loader #(
        .N_BINS (N_BINS),
        .CNT_W  (16),
        .SHIFT  (2)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .raw_valid             (raw_valid),
        .raw_ready             (raw_ready),
        .raw_count             (raw_count),
        .raw_last              (raw_last),
        .DATA_out_ready        (DATA_out_ready),
        .LOAD_input_value_ADDR (LOAD_input_value_ADDR),
        .LOAD_input_en         (LOAD_input_en),
        .Pre_processed_dat     (Pre_processed_dat),
        .PP_DONE               (PP_DONE),
        .short_frame           (short_frame)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] count, input logic last, input logic dor);
        raw_valid      = valid;
        raw_count      = count;
        raw_last       = last;
        DATA_out_ready = dor;
    endtask

    function automatic logic [31:0] frame_view(input logic mask);
        return {10'b0, raw_ready, PP_DONE, LOAD_input_en,
                mask ? LOAD_input_value_ADDR : 10'd0,
                mask ? Pre_processed_dat : 8'd0, 1'b0};
    endfunction

    function automatic logic [31:0] all_outputs();
        return {9'b0, raw_ready, LOAD_input_value_ADDR, LOAD_input_en,
                Pre_processed_dat, PP_DONE, short_frame, 1'b0};
    endfunction

    task automatic fill_ramp();
        for (int k = 0; k < N_BINS; k++) begin
            cnt_tab[k] = 16'(k * 4);
            exp_tab[k] = (k > 255) ? 8'd255 : 8'(k);
        end
    endtask

    // Runs one frame from index 0; indices past last_idx must read back as zero writes.
    task automatic run_frame(input int last_idx, input int spur_idx, input int abort_idx);
        logic       exp_en, exp_pp, exp_ready;
        logic [9:0] exp_addr;
        logic [7:0] exp_dat;
        applyStimulus(1'b1, cnt_tab[0], last_idx == 0, 1'b0);
        for (int c = 1; c <= N_BINS + 1; c++) begin
            @(posedge clk);
            #1;
            exp_en    = (c <= N_BINS);
            exp_pp    = (c == N_BINS + 1);
            exp_ready = (c <= last_idx);
            exp_addr  = exp_en ? 10'(c - 1) : 10'd0;
            exp_dat   = (exp_en && (c - 1) <= last_idx) ? exp_tab[c - 1] : 8'd0;
            checkOutput($sformatf("frame(last=%0d) cycle %0d", last_idx, c), frame_view(exp_en),
                        {10'b0, exp_ready, exp_pp, exp_en, exp_addr, exp_dat, 1'b0});
            if (c == 1) begin
                checkOutput("short_frame after first accept", {31'b0, short_frame}, {31'b0, last_idx == 0});
            end
            if (c == N_BINS + 1) begin
                checkOutput("short_frame at PP_DONE", {31'b0, short_frame}, {31'b0, last_idx < N_BINS - 1});
            end
            if (c == abort_idx) begin
                applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
                #2 rst_n = 1'b0;
                #1;
                checkOutput("outputs during mid-frame reset", all_outputs(), 32'd0);
                return;
            end
            if (c <= last_idx) begin
                applyStimulus(1'b1, cnt_tab[c], c == last_idx, c == spur_idx);
            end else begin
                applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic release_layer(input logic hold_valid, input logic exp_short);
        applyStimulus(hold_valid, 16'h00AA, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(hold_valid, 16'h00AA, 1'b0, 1'b0);
        checkOutput("release: ready/en/pp/short", {28'b0, raw_ready, LOAD_input_en, PP_DONE, short_frame},
                    {28'b0, 1'b1, 1'b0, 1'b0, exp_short});
    endtask

    initial begin
        sat_tab[0] = '{16'd1000,  8'd250};
        sat_tab[1] = '{16'd1020,  8'd255};
        sat_tab[2] = '{16'd1023,  8'd255};
        sat_tab[3] = '{16'd1024,  8'd255};
        sat_tab[4] = '{16'hFFFF,  8'd255};
        sat_tab[5] = '{16'd0,     8'd0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        #1;
        checkOutput("outputs in reset", all_outputs(), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle after reset", all_outputs(), {9'b0, 1'b1, 22'd0});

        $display("[TB] full frame, continuous valid");
        fill_ramp();
        run_frame(N_BINS - 1, -1, -1);

        $display("[TB] backpressure while waiting for layer");
        applyStimulus(1'b1, 16'h0123, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("backpressure cycle %0d", i),
                        {29'b0, raw_ready, LOAD_input_en, PP_DONE}, 32'd0);
        end
        release_layer(1'b1, 1'b0);

        $display("[TB] saturation vectors as a short frame");
        for (int i = 0; i < 6; i++) begin
            cnt_tab[i] = sat_tab[i].count;
            exp_tab[i] = sat_tab[i].expected;
        end
        run_frame(5, -1, -1);
        fill_ramp();
        release_layer(1'b0, 1'b1);

        $display("[TB] short frame ending at index 4");
        run_frame(4, -1, -1);
        release_layer(1'b0, 1'b1);

        $display("[TB] spurious DATA_out_ready mid-frame");
        run_frame(N_BINS - 1, 300, -1);
        release_layer(1'b0, 1'b0);

        $display("[TB] reset mid-frame at index 500");
        run_frame(N_BINS - 1, -1, 501);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle after abort %0d", i),
                        {29'b0, raw_ready, LOAD_input_en, PP_DONE}, {29'b0, 1'b1, 1'b0, 1'b0});
        end
        run_frame(N_BINS - 1, -1, -1);
        release_layer(1'b0, 1'b0);

        $display("[TB] raw_last on index 0");
        run_frame(0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
